mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 50 +++++
 rtl/mau_load_align.sv | 32 +++
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access-size codes, FSM
// states, the default bus timeout and the store-side lane helpers.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Size 11 is never legal, so it is reported as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data is replicated on every lane so the byte enables alone pick the target.
    function automatic logic [31:0] replicate_store(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_B:    rep = {4{data[7:0]}};
            SZ_H:    rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mau_load_align.sv
// Load-side lane selection: picks the addressed byte/half out of the bus
// word and sign- or zero-extends it to 32 bits.
module mau_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  byte_off,
    input  logic [1:0]  size,
    input  logic        se_s,
    output logic [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed lane and extend it; se_s=1 means zero-extend.
    always_comb begin
        case (byte_off)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    ext_data = se_s ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    ext_data = se_s ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: turns one load/store request from the control unit
// into a single bus transaction with alignment checking, ack timeout and
// a memory data register holding the extended load result.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        rd_start,
    input  logic        wr_start,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  Size_s,
    input  logic        SE_s,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait;
    logic          r_ok;
    logic          r_is_rd;
    logic [1:0]    r_size;
    logic [1:0]    r_off;
    logic          r_se;
    logic          r_bus_we;
    logic [31:0]   r_bus_addr;
    logic [3:0]    r_bus_be;
    logic [31:0]   r_bus_wdata;
    logic [31:0]   r_mdr;
    logic [31:0]   w_ext;

    logic w_start;
    logic w_bad;
    logic w_accept;
    logic w_timeout;

    assign w_start   = rd_start | wr_start;
    assign w_bad     = (rd_start & wr_start) | is_misaligned(Size_s, addr[1:0]);
    assign w_accept  = (r_state == ST_IDLE) & w_start & ~w_bad;
    // The last permitted REQ cycle without ack; an ack in that cycle still wins.
    assign w_timeout = ~bus_ack & (r_wait == WAIT_LAST);

    mau_load_align u_align (
        .rdata    (bus_rdata),
        .byte_off (r_off),
        .size     (r_size),
        .se_s     (r_se),
        .ext_data (w_ext)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; rejected requests skip the bus and report in RESP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_next = w_bad ? ST_RESP : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack || w_timeout) begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Status and bus request decoded from the current state.
    always_comb begin
        busy    = (r_state != ST_IDLE);
        bus_req = (r_state == ST_REQ);
        done    = (r_state == ST_RESP) &  r_ok;
        err     = (r_state == ST_RESP) & ~r_ok;
    end

    // Request latching, wait counting, outcome flag and load result capture.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wait      <= '0;
            r_ok        <= 1'b0;
            r_is_rd     <= 1'b0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_se        <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_be    <= '0;
            r_bus_wdata <= '0;
            r_mdr       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_ok <= 1'b0;
                    end
                    if (w_accept) begin
                        r_wait      <= '0;
                        r_is_rd     <= rd_start;
                        r_size      <= Size_s;
                        r_off       <= addr[1:0];
                        r_se        <= SE_s;
                        r_bus_we    <= wr_start;
                        r_bus_addr  <= {addr[31:2], 2'b00};
                        r_bus_be    <= lane_enables(Size_s, addr[1:0]);
                        r_bus_wdata <= replicate_store(Size_s, wdata);
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        r_ok <= 1'b1;
                        if (r_is_rd) begin
                            r_mdr <= w_ext;
                        end
                    end else if (!w_timeout) begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_be    = r_bus_be;
    assign bus_wdata = r_bus_wdata;
    assign mdr       = r_mdr;

endmodule
